// File: rtl/mac_pkg.sv
// Shared instruction encodings and control-FSM state type for the MAC array.
package mac_pkg;

    localparam int INST_BW = 2;

    localparam logic [INST_BW-1:0] INST_NOP     = 2'b00;
    localparam logic [INST_BW-1:0] INST_LOAD    = 2'b01;
    localparam logic [INST_BW-1:0] INST_EXEC    = 2'b10;
    localparam logic [INST_BW-1:0] INST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/inst_skew.sv
// Reset-clearable instruction delay line; taps[i] carries the input delayed by i+1 cycles.
module inst_skew
    import mac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = INST_BW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [W-1:0]              din,
    output logic [DEPTH-1:0][W-1:0]   taps
);

    always_ff @(posedge clk) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/mac_row.sv
// One weight-stationary MAC row: data and instruction ripple east one tile per cycle,
// each tile registers north psum + activation*weight on execute.
module mac_row
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int COL     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BW-1:0]            in_w,
    input  logic [INST_BW-1:0]       inst_w,
    input  logic [PSUM_BW*COL-1:0]   in_n,
    output logic [PSUM_BW*COL-1:0]   out_s,
    output logic [COL-1:0]           valid
);

    logic [BW-1:0]      a_chain [COL+1];
    logic [INST_BW-1:0] i_chain [COL+1];
    logic               unused_tail;

    assign a_chain[0] = in_w;
    assign i_chain[0] = inst_w;

    for (genvar c = 0; c < COL; c++) begin : g_tile
        logic [BW-1:0]             a_q;
        logic [BW-1:0]             w_q;
        logic [INST_BW-1:0]        i_q;
        logic [PSUM_BW-1:0]        psum_q;
        logic                      v_q;
        logic signed [PSUM_BW-1:0] prod;

        // Sign-extend before multiplying so the product wraps at PSUM_BW like the psum.
        assign prod = PSUM_BW'($signed(a_chain[c])) * PSUM_BW'($signed(w_q));

        always_ff @(posedge clk) begin
            if (reset) begin
                a_q    <= '0;
                w_q    <= '0;
                i_q    <= '0;
                psum_q <= '0;
                v_q    <= 1'b0;
            end else begin
                a_q <= a_chain[c];
                i_q <= i_chain[c];
                v_q <= i_chain[c][1];
                if (i_chain[c][0]) begin
                    w_q <= a_chain[c];
                end
                if (i_chain[c][1]) begin
                    psum_q <= in_n[c*PSUM_BW +: PSUM_BW] + prod;
                end
            end
        end

        assign a_chain[c+1]                 = a_q;
        assign i_chain[c+1]                 = i_q;
        assign out_s[c*PSUM_BW +: PSUM_BW]  = psum_q;
        assign valid[c]                     = v_q;
    end

    assign unused_tail = ^{a_chain[COL], i_chain[COL]};

endmodule

// File: rtl/mac_array_gen.sv
// Parametrised systolic MAC array: ROW stacked mac_rows, instruction skew line, activity FSM.
// Define MAC_ARRAY_PSUM_IN_EN to feed row 0 from the in_n port instead of zero.
module mac_array_gen
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int CNT_BW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROW*BW-1:0]        in_w,
    input  logic [1:0]               inst_w,
    input  logic [PSUM_BW*COL-1:0]   in_n,
    output logic [PSUM_BW*COL-1:0]   out_s,
    output logic [COL-1:0]           valid,
    output logic                     busy,
    output logic                     inst_err,
    output logic [CNT_BW-1:0]        out_cnt
);

    localparam int DRAIN_BW = $clog2(ROW + COL);
    localparam logic [DRAIN_BW-1:0] DRAIN_LOAD = DRAIN_BW'(ROW + COL - 1);

    logic [INST_BW-1:0]                inst_san;
    logic [ROW-1:0][INST_BW-1:0]       skew_taps;
    logic [ROW:0][PSUM_BW*COL-1:0]     psum_chain;
    logic [ROW-1:0][COL-1:0]           row_valid;
    logic                              unused_valid;
    state_t                            state;
    logic [DRAIN_BW-1:0]               drain_cnt;

    assign inst_san = (inst_w == INST_ILLEGAL) ? INST_NOP : inst_w;

    inst_skew #(
        .DEPTH (ROW),
        .W     (INST_BW)
    ) u_skew (
        .clk   (clk),
        .reset (reset),
        .din   (inst_san),
        .taps  (skew_taps)
    );

`ifdef MAC_ARRAY_PSUM_IN_EN
    assign psum_chain[0] = in_n;
`else
    logic unused_in_n;
    assign psum_chain[0] = '0;
    assign unused_in_n   = ^in_n;
`endif

    for (genvar r = 0; r < ROW; r++) begin : g_row
        mac_row #(
            .BW      (BW),
            .PSUM_BW (PSUM_BW),
            .COL     (COL)
        ) u_row (
            .clk    (clk),
            .reset  (reset),
            .in_w   (in_w[r*BW +: BW]),
            .inst_w (skew_taps[r]),
            .in_n   (psum_chain[r]),
            .out_s  (psum_chain[r+1]),
            .valid  (row_valid[r])
        );
    end

    assign out_s        = psum_chain[ROW];
    assign valid        = row_valid[ROW-1];
    assign unused_valid = ^row_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            inst_err  <= 1'b0;
            out_cnt   <= '0;
        end else begin
            if (inst_w == INST_ILLEGAL) begin
                inst_err <= 1'b1;
            end
            if (valid[0] && out_cnt != '1) begin
                out_cnt <= out_cnt + CNT_BW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (inst_san == INST_LOAD) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end else if (inst_san == INST_EXEC) begin
                        state <= S_EXEC;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (inst_san == INST_EXEC) begin
                        state <= S_EXEC;
                    end else if (inst_san == INST_NOP) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                S_EXEC: begin
                    if (inst_san == INST_LOAD) begin
                        state <= S_LOAD;
                    end else if (inst_san == INST_NOP) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    // busy drops together with the return to IDLE, ROW+COL edges after entry.
                    if (inst_san == INST_LOAD) begin
                        state     <= S_LOAD;
                        drain_cnt <= '0;
                    end else if (inst_san == INST_EXEC) begin
                        state     <= S_EXEC;
                        drain_cnt <= '0;
                    end else if (drain_cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
